// File: rtl/sparsynergy_pkg.sv
// sparsynergy_pkg: shared mode encoding and default geometry for the sparse activation path.
// Revision 1.0
`default_nettype none

package sparsynergy_pkg;

   typedef enum logic {
      MODE_SPARSE = 1'b0,
      MODE_DENSE  = 1'b1
   } mode_e;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_M      = 4;
   localparam int DEF_N      = 2;

endpackage

`default_nettype wire

// File: rtl/nm_lane_mux.sv
// nm_lane_mux: M:1 activation mux for one output lane; out-of-range index yields zero and err_o.
// Revision 1.0
`default_nettype none

module nm_lane_mux
   import sparsynergy_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int M      = DEF_M,
   parameter int IDX_W  = $clog2(M)
) (
   input  logic [M*DATA_W-1:0] act_i,
   input  logic [IDX_W-1:0]    idx_i,
   output logic [DATA_W-1:0]   act_o,
   output logic                err_o
);

   localparam logic [IDX_W:0] c_m = (IDX_W+1)'(M);

   assign err_o = ({1'b0, idx_i} >= c_m);

   always_comb begin
      act_o = '0;
      for (int j = 0; j < M; j++) begin
         if (idx_i == IDX_W'(j)) begin
            act_o = act_i[j*DATA_W +: DATA_W];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/nm_act_selector.sv
// nm_act_selector: registered N:M activation selector, sparse index pick or dense serialisation.
// Revision 1.0
`default_nettype none

module nm_act_selector
   import sparsynergy_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int M      = DEF_M,
   parameter int N      = DEF_N,
   parameter int IDX_W  = $clog2(M)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [M*DATA_W-1:0] in_act,
   input  logic [N*IDX_W-1:0]  in_idx,
   input  logic                in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*DATA_W-1:0] out_act,
   output logic                out_last,
   output logic                out_err
);

   localparam int c_beats  = M / N;
   localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;
   localparam int c_slots  = 2 ** c_beat_w;
   localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_emit = 1'b1;

   if ((M % N) != 0 || N > M) begin : g_param_check
      $error("nm_act_selector: M must be a multiple of N and N <= M");
   end

   logic [0:0]          state_q,    state_d;
   logic [c_beat_w-1:0] beat_cnt_q, beat_cnt_d;
   logic [M*DATA_W-1:0] grp_q,      grp_d;
   logic [N*DATA_W-1:0] out_act_q,  out_act_d;
   logic                out_last_q, out_last_d;
   logic                out_err_q,  out_err_d;

   logic [N*DATA_W-1:0] w_sparse_act;
   logic [N-1:0]        w_lane_err;
   logic                w_order_err;
   logic [N*DATA_W-1:0] w_beat [c_slots];
   logic [c_beat_w-1:0] w_next_beat;
   logic                w_in_fire;
   logic                w_out_fire;
   mode_e               w_mode;

   for (genvar k = 0; k < N; k++) begin : g_lane
      nm_lane_mux #(
         .DATA_W (DATA_W),
         .M      (M),
         .IDX_W  (IDX_W)
      ) u_lane_mux (
         .act_i (in_act),
         .idx_i (in_idx[k*IDX_W +: IDX_W]),
         .act_o (w_sparse_act[k*DATA_W +: DATA_W]),
         .err_o (w_lane_err[k])
      );
   end

   always_comb begin
      w_order_err = 1'b0;
      for (int k = 1; k < N; k++) begin
         if (in_idx[k*IDX_W +: IDX_W] <= in_idx[(k-1)*IDX_W +: IDX_W]) begin
            w_order_err = 1'b1;
         end
      end
   end

   // Beat slots past the last real beat are tied off so the counter can index a power-of-2 table.
   for (genvar b = 0; b < c_slots; b++) begin : g_beat
      if (b < c_beats) begin : g_used
         assign w_beat[b] = grp_q[b*N*DATA_W +: N*DATA_W];
      end else begin : g_pad
         assign w_beat[b] = '0;
      end
   end

   assign w_mode      = mode_e'(in_mode);
   assign out_valid   = (state_q == c_st_emit);
   assign w_out_fire  = out_valid && out_ready;
   assign in_ready    = (state_q == c_st_idle) || (w_out_fire && out_last_q);
   assign w_in_fire   = in_valid && in_ready;
   assign w_next_beat = beat_cnt_q + c_beat_w'(1);

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      grp_d      = grp_q;
      out_act_d  = out_act_q;
      out_last_d = out_last_q;
      out_err_d  = out_err_q;
      if (w_in_fire) begin
         state_d    = c_st_emit;
         beat_cnt_d = '0;
         grp_d      = in_act;
         if (w_mode == MODE_DENSE) begin
            out_act_d  = in_act[N*DATA_W-1:0];
            out_last_d = (c_beats == 1);
            out_err_d  = 1'b0;
         end else begin
            out_act_d  = w_sparse_act;
            out_last_d = 1'b1;
            out_err_d  = (|w_lane_err) || w_order_err;
         end
      end else if (w_out_fire) begin
         if (out_last_q) begin
            state_d = c_st_idle;
         end else begin
            beat_cnt_d = w_next_beat;
            out_act_d  = w_beat[w_next_beat];
            out_last_d = (w_next_beat == c_last_beat);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= c_st_idle;
         beat_cnt_q <= '0;
         grp_q      <= '0;
         out_act_q  <= '0;
         out_last_q <= 1'b0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         grp_q      <= grp_d;
         out_act_q  <= out_act_d;
         out_last_q <= out_last_d;
         out_err_q  <= out_err_d;
      end
   end

   assign out_act  = out_act_q;
   assign out_last = out_last_q;
   assign out_err  = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_nm_act_selector.sv
// tb_nm_act_selector: table vectors, directed corner sequences and a scoreboard over three geometries.
// Revision 1.0
`default_nettype none

module tb_nm_act_selector;

   typedef struct packed {
      logic [63:0] act;
      logic        last;
      logic        err;
   } beat_t;

   typedef struct {
      logic [31:0] act;
      logic [3:0]  idx;
      logic [15:0] exp_act;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   // A: M=4 N=2 DATA_W=8
   logic        a_iv, a_ir, a_md, a_ov, a_ordy, a_ol, a_oe;
   logic [31:0] a_ia;
   logic [3:0]  a_ix;
   logic [15:0] a_oa;
   // B: M=8 N=2 DATA_W=16
   logic         b_iv, b_ir, b_md, b_ov, b_ordy, b_ol, b_oe;
   logic [127:0] b_ia;
   logic [5:0]   b_ix;
   logic [31:0]  b_oa;
   // C: M=2 N=2 DATA_W=8
   logic        c_iv, c_ir, c_md, c_ov, c_ordy, c_ol, c_oe;
   logic [15:0] c_ia;
   logic [1:0]  c_ix;
   logic [15:0] c_oa;

   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t sb_q [3][$];
   vec_t  vecs [6];

   always #5 clk = ~clk;

   nm_act_selector #(.DATA_W(8), .M(4), .N(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_act(a_ia),
      .in_idx(a_ix), .in_mode(a_md), .out_valid(a_ov), .out_ready(a_ordy),
      .out_act(a_oa), .out_last(a_ol), .out_err(a_oe));

   nm_act_selector #(.DATA_W(16), .M(8), .N(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_act(b_ia),
      .in_idx(b_ix), .in_mode(b_md), .out_valid(b_ov), .out_ready(b_ordy),
      .out_act(b_oa), .out_last(b_ol), .out_err(b_oe));

   nm_act_selector #(.DATA_W(8), .M(2), .N(2)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_act(c_ia),
      .in_idx(c_ix), .in_mode(c_md), .out_valid(c_ov), .out_ready(c_ordy),
      .out_act(c_oa), .out_last(c_ol), .out_err(c_oe));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic beat_t model_beat(input int m, input int n, input int dw, input int iw,
                                        input logic [127:0] act, input logic [15:0] idx,
                                        input logic md, input int b);
      beat_t        r;
      logic [127:0] mask;
      logic [127:0] lane;
      int           ix;
      int           prev;
      mask   = (128'd1 << dw) - 128'd1;
      r.act  = '0;
      r.last = 1'b1;
      r.err  = 1'b0;
      prev   = -1;
      for (int k = 0; k < n; k++) begin
         if (md) begin
            lane = (act >> ((b*n + k)*dw)) & mask;
         end else begin
            ix = int'((idx >> (k*iw)) & 16'((1 << iw) - 1));
            if (ix < m) begin
               lane = (act >> (ix*dw)) & mask;
            end else begin
               lane  = '0;
               r.err = 1'b1;
            end
            if (k > 0 && ix <= prev) r.err = 1'b1;
            prev = ix;
         end
         r.act = r.act | 64'(lane << (k*dw));
      end
      if (md) r.last = (b == m/n - 1);
      return r;
   endfunction

   task automatic sb_step(input int id, input int m, input int n, input int dw, input int iw,
                          input string nm, input logic iv, input logic ir,
                          input logic [127:0] ia, input logic [15:0] ix, input logic md,
                          input logic ov, input logic ordy, input logic [63:0] oa,
                          input logic ol, input logic oe);
      beat_t e;
      if (ov && ordy) begin
         if (sb_q[id].size() == 0) begin
            chk({nm, " pending beats at output"}, 64'(sb_q[id].size()), 64'd1);
         end else begin
            e = sb_q[id].pop_front();
            chk({nm, " sb act"},  oa,      e.act);
            chk({nm, " sb last"}, 64'(ol), 64'(e.last));
            chk({nm, " sb err"},  64'(oe), 64'(e.err));
         end
      end
      if (iv && ir) begin
         for (int b = 0; b < (md ? m/n : 1); b++) begin
            sb_q[id].push_back(model_beat(m, n, dw, iw, ia, ix, md, b));
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) sb_q[i].delete();
      end else begin
         sb_step(0, 4, 2, 8, 2, "A", a_iv, a_ir, 128'(a_ia), 16'(a_ix), a_md,
                 a_ov, a_ordy, 64'(a_oa), a_ol, a_oe);
         sb_step(1, 8, 2, 16, 3, "B", b_iv, b_ir, b_ia, 16'(b_ix), b_md,
                 b_ov, b_ordy, 64'(b_oa), b_ol, b_oe);
         sb_step(2, 2, 2, 8, 1, "C", c_iv, c_ir, 128'(c_ia), 16'(c_ix), c_md,
                 c_ov, c_ordy, 64'(c_oa), c_ol, c_oe);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected %0d", 0);
      $fatal(1, "watchdog");
   end

   initial begin
      // idx lanes packed lane0 in the low bits
      vecs[0] = '{32'h44332211, {2'd3, 2'd1}, 16'h4422, 1'b0};
      vecs[1] = '{32'h44332211, {2'd1, 2'd1}, 16'h2222, 1'b1};
      vecs[2] = '{32'h44332211, {2'd2, 2'd0}, 16'h3311, 1'b0};
      vecs[3] = '{32'h44332211, {2'd0, 2'd3}, 16'h1144, 1'b1};
      vecs[4] = '{32'hDEADBEEF, {2'd3, 2'd0}, 16'hDEEF, 1'b0};
      vecs[5] = '{32'hA0B0C0D0, {2'd2, 2'd2}, 16'hB0B0, 1'b1};

      rst_n = 1'b0;
      a_iv = 0; a_md = 0; a_ia = '0; a_ix = '0; a_ordy = 1;
      b_iv = 0; b_md = 0; b_ia = '0; b_ix = '0; b_ordy = 1;
      c_iv = 0; c_md = 0; c_ia = '0; c_ix = '0; c_ordy = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 64'(a_ov), 64'd0);
      chk("reset out_act",   64'(a_oa), 64'd0);
      chk("reset out_last",  64'(a_ol), 64'd0);
      chk("reset out_err",   64'(a_oe), 64'd0);
      chk("reset in_ready",  64'(a_ir), 64'd1);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         a_iv = 1; a_md = 0; a_ia = vecs[i].act; a_ix = vecs[i].idx;
         #1;
         chk($sformatf("vec%0d in_ready", i), 64'(a_ir), 64'd1);
         tick();
         chk($sformatf("vec%0d out_valid", i), 64'(a_ov), 64'd1);
         chk($sformatf("vec%0d out_act", i),   64'(a_oa), 64'(vecs[i].exp_act));
         chk($sformatf("vec%0d out_last", i),  64'(a_ol), 64'd1);
         chk($sformatf("vec%0d out_err", i),   64'(a_oe), 64'(vecs[i].exp_err));
      end
      a_iv = 0;
      tick();
      chk("drain out_valid", 64'(a_ov), 64'd0);

      // dense group with a 3-cycle stall on beat 0
      a_md = 1; a_ia = 32'h44332211; a_ix = '1; a_iv = 1;
      tick();
      a_iv = 0;
      #1;
      chk("dense b0 act",      64'(a_oa), 64'h2211);
      chk("dense b0 last",     64'(a_ol), 64'd0);
      chk("dense b0 err",      64'(a_oe), 64'd0);
      chk("dense b0 in_ready", 64'(a_ir), 64'd0);
      a_ordy = 0; a_iv = 1; a_md = 0; a_ia = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall out_valid", 64'(a_ov), 64'd1);
         chk("stall out_act",   64'(a_oa), 64'h2211);
         chk("stall in_ready",  64'(a_ir), 64'd0);
      end
      a_iv = 0; a_ordy = 1;
      #1;
      chk("dense b0 ready after stall", 64'(a_ir), 64'd0);
      tick();
      chk("dense b1 act",      64'(a_oa), 64'h4433);
      chk("dense b1 last",     64'(a_ol), 64'd1);
      chk("dense b1 in_ready", 64'(a_ir), 64'd1);
      tick();
      chk("dense done out_valid", 64'(a_ov), 64'd0);

      // back-to-back dense groups
      a_md = 1; a_ia = 32'h44332211; a_iv = 1;
      tick();
      a_ia = 32'h88776655;
      chk("b2b A0", 64'(a_oa), 64'h2211);
      tick();
      chk("b2b A1", 64'(a_oa), 64'h4433);
      tick();
      a_iv = 0;
      chk("b2b B0 valid", 64'(a_ov), 64'd1);
      chk("b2b B0",       64'(a_oa), 64'h6655);
      tick();
      chk("b2b B1",      64'(a_oa), 64'h8877);
      chk("b2b B1 last", 64'(a_ol), 64'd1);
      tick();

      // reset in the middle of a dense group
      a_md = 1; a_ia = 32'h44332211; a_iv = 1;
      tick();
      a_iv = 0;
      chk("pre-reset out_valid", 64'(a_ov), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 64'(a_ov), 64'd0);
      chk("async reset out_act",   64'(a_oa), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post-reset idle", 64'(a_ov), 64'd0);
      end
      a_md = 0; a_ia = 32'h44332211; a_ix = {2'd3, 2'd1}; a_iv = 1;
      tick();
      a_iv = 0;
      chk("post-reset beat valid", 64'(a_ov), 64'd1);
      chk("post-reset beat act",   64'(a_oa), 64'h4422);
      tick();

      // M == N dense: single beat flagged last
      c_md = 1; c_ia = 16'hBBAA; c_iv = 1;
      tick();
      c_iv = 0;
      chk("M==N dense act",  64'(c_oa), 64'hBBAA);
      chk("M==N dense last", 64'(c_ol), 64'd1);
      tick();

      for (int cyc = 0; cyc < 600; cyc++) begin
         a_iv = 1'($urandom); a_md = 1'($urandom); a_ia = $urandom; a_ix = 4'($urandom);
         a_ordy = ($urandom_range(0, 3) != 0);
         b_iv = 1'($urandom); b_md = 1'($urandom);
         b_ia = {$urandom, $urandom, $urandom, $urandom}; b_ix = 6'($urandom);
         b_ordy = ($urandom_range(0, 3) != 0);
         c_iv = 1'($urandom); c_md = 1'($urandom); c_ia = 16'($urandom); c_ix = 2'($urandom);
         c_ordy = ($urandom_range(0, 3) != 0);
         tick();
      end
      a_iv = 0; b_iv = 0; c_iv = 0;
      a_ordy = 1; b_ordy = 1; c_ordy = 1;
      for (int i = 0; i < 40 && (a_ov || b_ov || c_ov); i++) tick();
      tick();
      chk("A drained", 64'(sb_q[0].size()), 64'd0);
      chk("B drained", 64'(sb_q[1].size()), 64'd0);
      chk("C drained", 64'(sb_q[2].size()), 64'd0);
      chk("A idle",    64'(a_ov), 64'd0);
      chk("B idle",    64'(b_ov), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
